// File: rtl/pci_master_pkg.sv
// rtl/pci_master_pkg.sv - shared states, status codes and CSR bit indices for the PCI master engine
package pci_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_XFER = 3'd2,
        ST_RTY  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STAT_OK         = 2'd0,
        STAT_RETRY_FAIL = 2'd1,
        STAT_ABORT      = 2'd2
    } status_t;

    localparam int CSR_ABORT_M = 39;
    localparam int CSR_ABORT_T = 38;
    localparam int CSR_RETRY   = 36;

    function automatic logic [3:0] bus_cmd(input logic dir, input logic [3:0] cmd_rd,
                                           input logic [3:0] cmd_wr);
        return dir ? cmd_wr : cmd_rd;
    endfunction

endpackage

// File: rtl/pci_master_engine_if.sv
// rtl/pci_master_engine_if.sv - user command/stream and core master signals of the PCI master engine
interface pci_master_engine_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_addr;
    logic             cmd_dir;
    logic [LEN_W-1:0] cmd_len;
    logic [31:0]      wr_data;
    logic             wr_pop;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             done;
    logic [1:0]       status;
    logic [31:0]      adio_out;
    logic [31:0]      adio_in;
    logic             adio_oe;
    logic             m_data;
    logic             m_data_vld;
    logic             m_addr_n;
    logic [39:0]      csr;
    logic             request;
    logic             requesthold;
    logic             complete;
    logic             m_ready;
    logic             m_wrdn;
    logic [3:0]       m_cbe;

    modport master (
        input  cmd_valid, cmd_addr, cmd_dir, cmd_len, wr_data, adio_out,
               m_data, m_data_vld, m_addr_n, csr,
        output cmd_ready, wr_pop, rd_data, rd_valid, done, status, adio_in, adio_oe,
               request, requesthold, complete, m_ready, m_wrdn, m_cbe
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_dir, cmd_len, wr_data, adio_out,
               m_data, m_data_vld, m_addr_n, csr,
        input  cmd_ready, wr_pop, rd_data, rd_valid, done, status, adio_in, adio_oe,
               request, requesthold, complete, m_ready, m_wrdn, m_cbe
    );

endinterface

// File: rtl/pci_master_term.sv
// rtl/pci_master_term.sv - end-of-data-phase detection with fatal/retry termination flag capture
module pci_master_term (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_m_data,
    input  logic i_m_addr_n,
    input  logic i_abort_m,
    input  logic i_abort_t,
    input  logic i_retry,
    output logic o_m_data_fell,
    output logic o_fatal,
    output logic o_retry
);

    logic r_m_data;
    logic r_fatal;
    logic r_retry;

    // Flags track the latest data-phase CSR value and are wiped by each new address phase
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_m_data <= 1'b0;
            r_fatal  <= 1'b0;
            r_retry  <= 1'b0;
        end else begin
            r_m_data <= i_m_data;
            if (!i_m_addr_n) begin
                r_fatal <= 1'b0;
                r_retry <= 1'b0;
            end else if (i_m_data) begin
                r_fatal <= i_abort_m | i_abort_t;
                r_retry <= i_retry;
            end
        end
    end

    assign o_m_data_fell = ~i_m_data & r_m_data;
    assign o_fatal       = r_fatal;
    assign o_retry       = r_retry;

endmodule

// File: rtl/pci_master_engine.sv
// rtl/pci_master_engine.sv - burst PCI initiator sequencer with retry resume and abort reporting
module pci_master_engine
    import pci_master_pkg::*;
#(
    parameter int         LEN_W     = 8,
    parameter int         MAX_RETRY = 15,
    parameter int         RETRY_W   = 4,
    parameter logic [3:0] CMD_RD    = 4'h6,
    parameter logic [3:0] CMD_WR    = 4'h7
) (
    input  logic                 CLK,
    input  logic                 reset,
    pci_master_engine_if.master  bus
);

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_addr, w_addr_nxt;
    logic               r_dir, w_dir_nxt;
    logic [LEN_W-1:0]   r_rem, w_rem_nxt;
    logic [RETRY_W-1:0] r_rcnt, w_rcnt_nxt;
    status_t            r_status, w_status_nxt;
    logic               r_m_ready;
    logic               r_complete;

    logic w_fell;
    logic w_fatal;
    logic w_retry;
    logic w_beat;
    logic w_complete_nxt;
    logic w_unused_csr;

    pci_master_term u_term (
        .i_clk         (CLK),
        .i_reset       (reset),
        .i_m_data      (bus.m_data),
        .i_m_addr_n    (bus.m_addr_n),
        .i_abort_m     (bus.csr[CSR_ABORT_M]),
        .i_abort_t     (bus.csr[CSR_ABORT_T]),
        .i_retry       (bus.csr[CSR_RETRY]),
        .o_m_data_fell (w_fell),
        .o_fatal       (w_fatal),
        .o_retry       (w_retry)
    );

    assign w_unused_csr = ^{bus.csr[37], bus.csr[35:0]};

    // Beats past the end of the burst are dropped so the user streams never over-run
    assign w_beat = (r_state == ST_XFER) && bus.m_data_vld && (r_rem != '0);

    assign w_complete_nxt = (r_state == ST_XFER) &&
                            ((r_rem <= LEN_W'(1)) || ((r_rem == LEN_W'(2)) && bus.m_data_vld));

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_dir      <= 1'b0;
            r_rem      <= '0;
            r_rcnt     <= '0;
            r_status   <= STAT_OK;
            r_m_ready  <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_dir      <= w_dir_nxt;
            r_rem      <= w_rem_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_status   <= w_status_nxt;
            r_m_ready  <= 1'b1;
            r_complete <= w_complete_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_dir_nxt    = r_dir;
        w_rem_nxt    = r_rem;
        w_rcnt_nxt   = r_rcnt;
        w_status_nxt = r_status;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_addr_nxt  = {bus.cmd_addr[31:2], 2'b00};
                    w_dir_nxt   = bus.cmd_dir;
                    w_rem_nxt   = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: w_state_nxt = ST_XFER;
            ST_XFER: begin
                if (w_beat) begin
                    w_addr_nxt = r_addr + 32'd4;
                    w_rem_nxt  = r_rem - LEN_W'(1);
                end
                if (w_fell) begin
                    if (w_fatal) begin
                        w_state_nxt  = ST_FIN;
                        w_status_nxt = STAT_ABORT;
                    end else if (w_retry || (r_rem != '0)) begin
                        w_state_nxt = ST_RTY;
                    end else begin
                        w_state_nxt  = ST_FIN;
                        w_status_nxt = STAT_OK;
                    end
                end
            end
            ST_RTY: begin
                // A plain disconnect resumes without consuming the retry budget
                if (!w_retry) begin
                    w_state_nxt = ST_REQ;
                end else if (r_rcnt == RETRY_W'(MAX_RETRY)) begin
                    w_state_nxt  = ST_FIN;
                    w_status_nxt = STAT_RETRY_FAIL;
                end else begin
                    w_rcnt_nxt  = r_rcnt + RETRY_W'(1);
                    w_state_nxt = ST_REQ;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.adio_in = '0;
        bus.adio_oe = 1'b0;
        bus.m_cbe   = 4'b0000;
        if ((r_state == ST_XFER) && !bus.m_addr_n) begin
            bus.adio_in = r_addr;
            bus.adio_oe = 1'b1;
            bus.m_cbe   = bus_cmd(r_dir, CMD_RD, CMD_WR);
        end else if ((r_state == ST_XFER) && bus.m_data && r_dir) begin
            bus.adio_in = bus.wr_data;
            bus.adio_oe = 1'b1;
        end
    end

    assign bus.cmd_ready   = (r_state == ST_IDLE);
    assign bus.request     = (r_state == ST_REQ);
    assign bus.requesthold = ((r_state == ST_REQ) || (r_state == ST_RTY)) && (r_rcnt != '0);
    assign bus.done        = (r_state == ST_FIN);
    assign bus.status      = r_status;
    assign bus.complete    = r_complete;
    assign bus.m_ready     = r_m_ready;
    assign bus.m_wrdn      = r_dir;
    assign bus.rd_data     = bus.adio_out;
    assign bus.rd_valid    = w_beat & ~r_dir;
    assign bus.wr_pop      = w_beat & r_dir;

endmodule

// File: tb/tb_pci_master_engine.sv
// tb/tb_pci_master_engine.sv - randomized self-checking bench for pci_master_engine with a burst-level model
module tb_pci_master_engine;

    localparam int MAXR = 2;
    localparam int T_NORMAL  = 0;
    localparam int T_RETRY   = 1;
    localparam int T_ABORT   = 2;
    localparam int T_ABORT_T = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pci_master_engine_if #(.LEN_W(8)) bus ();

    pci_master_engine #(
        .LEN_W     (8),
        .MAX_RETRY (MAXR),
        .RETRY_W   (4),
        .CMD_RD    (4'h6),
        .CMD_WR    (4'h7)
    ) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pl_words[$];
    int pl_term[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_dir    = 1'b0;
        bus.cmd_len    = '0;
        bus.wr_data    = '0;
        bus.adio_out   = '0;
        bus.m_data     = 1'b0;
        bus.m_data_vld = 1'b0;
        bus.m_addr_n   = 1'b1;
        bus.csr        = '0;
    endtask

    // Model: burst = sequence of bus tenures; each tenure moves up to 'remaining' words from the current address
    task automatic run_cmd(input logic [31:0] a, input logic d, input int len);
        logic [31:0] e_addr;
        logic [39:0] tbits;
        int rem, cnt, segs, term, words, extra, left, exp_stat, r;
        bit found, fin, vld, eff;
        e_addr = a & 32'hFFFF_FFFC;
        rem    = (len == 0) ? 1 : len;
        cnt    = 0;
        segs   = 0;
        cyc();
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_dir   = d;
        bus.cmd_len   = 8'(len);
        #1;
        check_eq("cmd_ready", 64'(bus.cmd_ready), 64'(1));
        cyc();
        bus.cmd_valid = 1'b0;
        while (1) begin
            found = 0;
            for (int i = 0; i < 8; i++) begin
                if (bus.request) begin
                    found = 1;
                    break;
                end
                check_eq("early_done", 64'(bus.done), 64'(0));
                cyc();
            end
            if (!found) begin
                check_eq("req_timeout", 64'(0), 64'(1));
                return;
            end
            check_eq("requesthold", 64'(bus.requesthold), 64'(cnt != 0));
            if (pl_term.size() > 0) begin
                term  = pl_term.pop_front();
                words = pl_words.pop_front();
                extra = 0;
            end else begin
                r = int'($urandom_range(0, 99));
                if (segs >= 10)  begin term = T_NORMAL; words = rem; end
                else if (r < 8)  begin term = T_ABORT;  words = int'($urandom_range(0, rem)); end
                else if (r < 40) begin term = T_RETRY;  words = int'($urandom_range(0, rem)); end
                else if (r < 55) begin term = T_NORMAL; words = int'($urandom_range(0, rem)); end
                else             begin term = T_NORMAL; words = rem; end
                extra = (term == T_NORMAL && words == rem && $urandom_range(0, 3) == 0) ? 1 : 0;
            end
            case (term)
                T_RETRY:   tbits = 40'h10_0000_0000;
                T_ABORT_T: tbits = 40'h40_0000_0000;
                T_ABORT:   tbits = $urandom_range(0, 1) ? 40'h80_0000_0000 : 40'h40_0000_0000;
                default:   tbits = '0;
            endcase
            cyc();
            bus.m_addr_n = 1'b0;
            #1;
            check_eq("req_one_cycle", 64'(bus.request), 64'(0));
            check_eq("addr_phase", 64'(bus.adio_in), 64'(e_addr));
            check_eq("addr_oe", 64'(bus.adio_oe), 64'(1));
            check_eq("m_cbe", 64'(bus.m_cbe), 64'(d ? 4'h7 : 4'h6));
            check_eq("m_wrdn", 64'(bus.m_wrdn), 64'(d));
            left = words + extra;
            do begin
                cyc();
                bus.m_addr_n   = 1'b1;
                bus.m_data     = 1'b1;
                vld            = (left > 0) && ($urandom_range(0, 3) != 0);
                bus.m_data_vld = vld;
                bus.adio_out   = $urandom;
                bus.wr_data    = $urandom;
                bus.csr        = ({$urandom, $urandom} & ~40'hD0_0000_0000) | tbits;
                bus.cmd_valid  = 1'($urandom_range(0, 1));
                bus.cmd_addr   = $urandom;
                #1;
                eff = vld && (rem > 0);
                check_eq("rd_valid", 64'(bus.rd_valid), 64'(eff && !d));
                check_eq("wr_pop", 64'(bus.wr_pop), 64'(eff && d));
                if (eff && !d) check_eq("rd_data", 64'(bus.rd_data), 64'(bus.adio_out));
                if (d) begin
                    check_eq("wr_adio", 64'(bus.adio_in), 64'(bus.wr_data));
                    check_eq("wr_oe", 64'(bus.adio_oe), 64'(1));
                end else begin
                    check_eq("rd_oe", 64'(bus.adio_oe), 64'(0));
                end
                if (rem == 1)      check_eq("complete_hi", 64'(bus.complete), 64'(1));
                else if (rem >= 3) check_eq("complete_lo", 64'(bus.complete), 64'(0));
                if (vld) left--;
                if (eff) begin
                    rem--;
                    e_addr = e_addr + 32'd4;
                end
            end while (left > 0);
            cyc();
            bus.m_data     = 1'b0;
            bus.m_data_vld = 1'b0;
            bus.csr        = '0;
            bus.cmd_valid  = 1'b0;
            #1;
            check_eq("idle_rd_valid", 64'(bus.rd_valid), 64'(0));
            check_eq("idle_wr_pop", 64'(bus.wr_pop), 64'(0));
            fin = 0;
            exp_stat = 0;
            if (term >= T_ABORT) begin
                fin = 1; exp_stat = 2;
            end else if (term == T_RETRY) begin
                if (cnt == MAXR) begin fin = 1; exp_stat = 1; end
                else cnt++;
            end else if (rem == 0) begin
                fin = 1; exp_stat = 0;
            end
            if (fin) begin
                found = 0;
                for (int i = 0; i < 8; i++) begin
                    cyc();
                    if (bus.done) begin
                        found = 1;
                        break;
                    end
                    check_eq("no_reissue", 64'(bus.request), 64'(0));
                end
                check_eq("done_seen", 64'(found), 64'(1));
                check_eq("status", 64'(bus.status), 64'(exp_stat));
                cyc();
                check_eq("done_pulse", 64'(bus.done), 64'(0));
                check_eq("back_idle", 64'(bus.cmd_ready), 64'(1));
                return;
            end
            segs++;
        end
    endtask

    task automatic reset_mid_burst();
        cyc();
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h3000_0000;
        bus.cmd_dir   = 1'b0;
        bus.cmd_len   = 8'd8;
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        bus.m_addr_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.m_addr_n   = 1'b1;
            bus.m_data     = 1'b1;
            bus.m_data_vld = 1'b1;
            bus.adio_out   = $urandom;
            #1;
            check_eq("rst_pre_rd_valid", 64'(bus.rd_valid), 64'(1));
        end
        cyc();
        reset          = 1'b1;
        bus.m_data     = 1'b0;
        bus.m_data_vld = 1'b0;
        cyc();
        check_eq("rst_request", 64'(bus.request), 64'(0));
        check_eq("rst_done", 64'(bus.done), 64'(0));
        check_eq("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check_eq("rst_status", 64'(bus.status), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("rst_no_done", 64'(bus.done), 64'(0));
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) cyc();
        check_eq("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check_eq("reset_request", 64'(bus.request), 64'(0));
        check_eq("reset_requesthold", 64'(bus.requesthold), 64'(0));
        check_eq("reset_complete", 64'(bus.complete), 64'(0));
        check_eq("reset_m_ready", 64'(bus.m_ready), 64'(0));
        check_eq("reset_done", 64'(bus.done), 64'(0));
        check_eq("reset_rd_valid", 64'(bus.rd_valid), 64'(0));
        check_eq("reset_wr_pop", 64'(bus.wr_pop), 64'(0));
        check_eq("reset_adio_oe", 64'(bus.adio_oe), 64'(0));
        check_eq("reset_status", 64'(bus.status), 64'(0));
        reset = 1'b0;
        cyc();
        check_eq("m_ready_up", 64'(bus.m_ready), 64'(1));

        pl_words = '{4};    pl_term = '{T_NORMAL};
        run_cmd(32'h1000_0000, 1'b0, 4);
        pl_words = '{3};    pl_term = '{T_NORMAL};
        run_cmd(32'h2000_0000, 1'b1, 3);
        pl_words = '{3, 5}; pl_term = '{T_RETRY, T_NORMAL};
        run_cmd(32'h1000_0000, 1'b0, 8);
        pl_words = '{1, 0, 0}; pl_term = '{T_RETRY, T_RETRY, T_RETRY};
        run_cmd(32'h4000_0010, 1'b0, 6);
        pl_words = '{1};    pl_term = '{T_ABORT_T};
        run_cmd(32'h5000_0000, 1'b1, 4);
        pl_words = '{0, 2}; pl_term = '{T_NORMAL, T_NORMAL};
        run_cmd(32'h6000_0003, 1'b0, 2);
        pl_words = '{1};    pl_term = '{T_NORMAL};
        run_cmd(32'h7000_0000, 1'b1, 0);

        reset_mid_burst();
        pl_words = '{2};    pl_term = '{T_NORMAL};
        run_cmd(32'h3000_0100, 1'b0, 2);

        for (int k = 0; k < 40; k++) begin
            run_cmd($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
